// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and FSM state type for the 5x5 convolution front end.
//   INPUT_WIDTH : pixel width expected by the convolution core
//   PATCH_DIM   : window edge length (5x5 patch)
//   state_t     : window-generator control states
package conv_pkg;

    localparam int unsigned INPUT_WIDTH = 8;
    localparam int unsigned PATCH_DIM   = 5;

    typedef enum logic [1:0] {
        S_FILL,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_IDLE
    } state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image row of delay (DEPTH entries x WIDTH bits).
// Synchronous write, asynchronous read at the same index, so a read-modify
// chain of these buffers forms a stack of row delays indexed by column.
// Ports:
//   clk   : clock
//   we    : write enable (pixel transfer)
//   idx   : column index used for both read and write
//   wdata : value stored at idx on the next edge when we=1
//   rdata : current contents at idx (value from the previous row)
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 28,
    parameter int WIDTH = INPUT_WIDTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/conv5x5_window_gen.sv
// conv5x5_window_gen: raster pixel stream -> stable 5x5 patches for the conv core.
// Keeps four row delays plus a 5x5 shift window. When a transfer completes a
// valid window position (r>=4, c>=4) the block issues a one-cycle start, then
// stalls input until the core has raised and dropped busy.
// Optional feature (macro CONV_WIN_STALL_CNT_EN): stall_clr input and a
// saturating 32-bit stall_cycles counter of cycles with pix_valid && !pix_ready.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   pix_in, pix_valid   : raster-order pixel stream
//   pix_ready           : pixel accepted when pix_valid && pix_ready
//   patch_pixels        : [row][col] window, row 0 oldest, col 0 leftmost
//   start_channel_proc  : one-cycle start to the core
//   core_busy           : core busy flag
//   out_row, out_col    : output grid position of the presented patch
//   frame_done          : one-cycle pulse when the last patch of a frame is released
module conv5x5_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = INPUT_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [PIX_W-1:0]                               pix_in,
    input  logic                                           pix_valid,
    output logic                                           pix_ready,
    output logic [0:PATCH_DIM-1][0:PATCH_DIM-1][PIX_W-1:0] patch_pixels,
    output logic                                           start_channel_proc,
    input  logic                                           core_busy,
    output logic [$clog2(IMG_H)-1:0]                       out_row,
    output logic [$clog2(IMG_W)-1:0]                       out_col,
    output logic                                           frame_done
`ifdef CONV_WIN_STALL_CNT_EN
    ,
    input  logic                                           stall_clr,
    output logic [31:0]                                    stall_cycles
`endif
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_OFF  = RW'(PATCH_DIM - 1);
    localparam logic [CW-1:0] C_OFF  = CW'(PATCH_DIM - 1);

    state_t state, state_next;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          xfer;
    logic          issue_pos;
    logic          issue;
    logic          last_pending;

    // lb_rd[k] is row r-1-k at column c; each buffer is fed by the one above it.
    logic [3:0][PIX_W-1:0] lb_rd;
    logic [3:0][PIX_W-1:0] lb_wr;

    assign xfer      = pix_valid && pix_ready;
    assign issue_pos = (row >= R_OFF) && (col >= C_OFF);
    assign issue     = xfer && issue_pos;
    assign lb_wr     = {lb_rd[2:0], pix_in};

    for (genvar k = 0; k < 4; k++) begin : g_lb
        conv_line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W),
            .IDX_W (CW)
        ) u_lb (
            .clk   (clk),
            .we    (xfer),
            .idx   (col),
            .wdata (lb_wr[k]),
            .rdata (lb_rd[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    // pix_ready is not read back here; the FILL decision uses pix_valid directly
    // so no combinational loop forms through the transfer handshake.
    always_comb begin
        state_next         = state;
        pix_ready          = 1'b0;
        start_channel_proc = 1'b0;
        frame_done         = 1'b0;
        case (state)
            S_FILL: begin
                pix_ready = 1'b1;
                if (pix_valid && issue_pos) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_channel_proc = 1'b1;
                state_next         = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (core_busy) begin
                    state_next = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!core_busy) begin
                    state_next = S_FILL;
                    frame_done = last_pending;
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            patch_pixels <= '0;
            row          <= '0;
            col          <= '0;
            out_row      <= '0;
            out_col      <= '0;
            last_pending <= 1'b0;
        end else if (xfer) begin
            for (int unsigned i = 0; i < PATCH_DIM; i++) begin
                for (int unsigned j = 0; j < PATCH_DIM - 1; j++) begin
                    patch_pixels[i][j] <= patch_pixels[i][j+1];
                end
            end
            patch_pixels[0][PATCH_DIM-1] <= lb_rd[3];
            patch_pixels[1][PATCH_DIM-1] <= lb_rd[2];
            patch_pixels[2][PATCH_DIM-1] <= lb_rd[1];
            patch_pixels[3][PATCH_DIM-1] <= lb_rd[0];
            patch_pixels[4][PATCH_DIM-1] <= pix_in;

            if (col == C_LAST) begin
                col <= '0;
                row <= (row == R_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end

            if (issue) begin
                out_row      <= row - R_OFF;
                out_col      <= col - C_OFF;
                last_pending <= (row == R_LAST) && (col == C_LAST);
            end
        end
    end

`ifdef CONV_WIN_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || stall_clr) begin
            stall_cycles <= '0;
        end else if (pix_valid && !pix_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv5x5_window_gen.sv
// tb_conv5x5_window_gen: self-checking bench for conv5x5_window_gen (8x6 image).
// Expected patches come from the image array by definition
// (patch[i][j] = img[out_row+i][out_col+j]); a negedge monitor compares every
// start, the one-cycle start latency, patch stability while stalled, and frame_done.
module tb_conv5x5_window_gen;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;

    typedef logic [0:4][0:4][7:0] patch_t;
    typedef struct {
        int     row;
        int     col;
        patch_t p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    patch_t     patch_pixels;
    logic       start_channel_proc;
    logic       core_busy;
    logic [2:0] out_row;
    logic [2:0] out_col;
    logic       frame_done;
`ifdef CONV_WIN_STALL_CNT_EN
    logic        stall_clr = 1'b0;
    logic [31:0] stall_cycles;
`endif

    conv5x5_window_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pix_in             (pix_in),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .patch_pixels       (patch_pixels),
        .start_channel_proc (start_channel_proc),
        .core_busy          (core_busy),
        .out_row            (out_row),
        .out_col            (out_col),
        .frame_done         (frame_done)
`ifdef CONV_WIN_STALL_CNT_EN
        ,
        .stall_clr          (stall_clr),
        .stall_cycles       (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] img [0:IMG_H-1][0:IMG_W-1];
    exp_t       exp_q[$];
    patch_t     firsts[$];
    patch_t     last_seen;
    int         start_cnt = 0;
    int         done_cnt  = 0;
    int         busy_len  = 30;
`ifdef CONV_WIN_STALL_CNT_EN
    logic [31:0] stall_log[$];
    logic        prev_done = 1'b0;
`endif

    function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endfunction

    function automatic void chk_patch(string name, patch_t got, patch_t want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endfunction

    function automatic void build_frame(int mode);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = (mode == 0) ? 8'(r * 8 + c) : 8'($urandom_range(0, 255));
    endfunction

    function automatic void push_patches();
        exp_t e;
        for (int orow = 0; orow <= IMG_H - 5; orow++)
            for (int ocol = 0; ocol <= IMG_W - 5; ocol++) begin
                e.row = orow;
                e.col = ocol;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        e.p[i][j] = img[orow+i][ocol+j];
                exp_q.push_back(e);
            end
    endfunction

    // Core model: busy rises the cycle after start and stays high busy_len cycles.
    int bcnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            core_busy <= 1'b0;
            bcnt      <= 0;
        end else if (start_channel_proc) begin
            core_busy <= 1'b1;
            bcnt      <= busy_len - 1;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end else begin
            core_busy <= 1'b0;
        end
    end

    // Monitor
    logic       iss_pend  = 1'b0;
    logic       pend_done = 1'b0;
    int         r_pos = 0;
    int         c_pos = 0;
    patch_t     held_p;
    logic [2:0] held_r, held_c;

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            iss_pend  = 1'b0;
            pend_done = 1'b0;
            r_pos     = 0;
            c_pos     = 0;
        end else begin
            chk("start_timing", start_channel_proc, iss_pend);
            if (start_channel_proc) begin
                start_cnt++;
                chk("done_before_next_start", pend_done, 1'b0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_start: got start at (%0d,%0d) expected none", out_row, out_col);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_row", out_row, e.row);
                    chk("out_col", out_col, e.col);
                    chk_patch("patch", patch_pixels, e.p);
                    if (e.row == IMG_H - 5 && e.col == IMG_W - 5) pend_done = 1'b1;
                end
                held_p = patch_pixels;
                held_r = out_row;
                held_c = out_col;
                if (out_row == 0 && out_col == 0) firsts.push_back(patch_pixels);
                last_seen = patch_pixels;
            end else if (!pix_ready) begin
                chk_patch("hold_patch", patch_pixels, held_p);
                chk("hold_row", out_row, held_r);
                chk("hold_col", out_col, held_c);
            end
`ifdef CONV_WIN_STALL_CNT_EN
            if (prev_done) stall_log.push_back(stall_cycles);
            prev_done = frame_done;
`endif
            if (frame_done) begin
                chk("frame_done_when", {pend_done, core_busy, pix_ready}, 3'b100);
                pend_done = 1'b0;
                done_cnt++;
            end
            iss_pend = 1'b0;
            if (pix_valid && pix_ready) begin
                iss_pend = (r_pos >= 4 && c_pos >= 4);
                if (c_pos == IMG_W - 1) begin
                    c_pos = 0;
                    r_pos = (r_pos == IMG_H - 1) ? 0 : r_pos + 1;
                end else begin
                    c_pos++;
                end
            end
        end
    end

    task automatic send_pixel(input logic [7:0] p);
        int g = 0;
        pix_in    = p;
        pix_valid = 1'b1;
        while (!pix_ready && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 2000) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got pix_ready=0 for %0d cycles expected 1", g);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int idle_pct);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                while ($urandom_range(0, 99) < idle_pct) begin
                    pix_valid = 1'b0;
                    @(posedge clk); #1;
                end
                send_pixel(img[r][c]);
            end
    endtask

    task automatic wait_done(input int target);
        int g = 0;
        while (done_cnt < target && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("frame_done_count", done_cnt, target);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
`ifdef CONV_WIN_STALL_CNT_EN
        stall_clr = 1'b1;
        @(posedge clk); #1;
        stall_clr = 1'b0;
`endif
    endtask

    initial begin : main
        patch_t f;
        int     s0;
        int     g;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_ready", pix_ready, 1'b1);
        chk("rst_start", start_channel_proc, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk_patch("rst_patch", patch_pixels, '0);
`ifdef CONV_WIN_STALL_CNT_EN
        chk("rst_stall", stall_cycles, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Two back-to-back ramp frames, continuous valid, busy 30 cycles.
        build_frame(0);
        push_patches();
        chk("model_n", exp_q.size(), 8);
        chk("model_p0_00", exp_q[0].p[0][0], 0);
        chk("model_p0_04", exp_q[0].p[0][4], 4);
        chk("model_p0_40", exp_q[0].p[4][0], 32);
        chk("model_p0_44", exp_q[0].p[4][4], 36);
        chk("model_p4_pos", {exp_q[4].row[7:0], exp_q[4].col[7:0]}, 16'h0100);
        chk("model_p7_pos", {exp_q[7].row[7:0], exp_q[7].col[7:0]}, 16'h0103);
        chk("model_p7_44", exp_q[7].p[4][4], 47);
        push_patches();
        pulse_clr();
        busy_len = 30;
        send_frame(0);
        send_frame(0);
        pix_valid = 1'b0;
        wait_done(2);
        chk("starts_two_frames", start_cnt, 16);
        chk("queue_empty_a", exp_q.size(), 0);
        chk("firsts_n", firsts.size(), 2);
        f = firsts[0];
        chk("dut_first_00", f[0][0], 0);
        chk("dut_first_04", f[0][4], 4);
        chk("dut_first_40", f[4][0], 32);
        chk("dut_first_44", f[4][4], 36);
        chk_patch("second_frame_first", firsts[1], firsts[0]);
        f = last_seen;
        chk("dut_last_44", f[4][4], 47);
`ifdef CONV_WIN_STALL_CNT_EN
        chk("stall_log_n", stall_log.size(), 2);
        chk("stall_frame1", stall_log[0], 256);
        chk("stall_frame2", stall_log[1], 256 + 7 * 32);
        chk("stall_final", stall_cycles, 256 + 7 * 32);
        pulse_clr();
        chk("stall_cleared", stall_cycles, 0);
`endif

        // Same ramp with 50% valid gaps.
        s0 = start_cnt;
        build_frame(0);
        push_patches();
        send_frame(50);
        pix_valid = 1'b0;
        wait_done(3);
        chk("starts_gappy", start_cnt - s0, 8);
        chk_patch("gappy_first", firsts[firsts.size()-1], firsts[0]);
        f = last_seen;
        chk("gappy_last_44", f[4][4], 47);

        // Random pixels, random busy lengths, random gaps.
        s0 = start_cnt;
        for (int k = 0; k < 3; k++) begin
            busy_len = $urandom_range(1, 8);
            build_frame(1);
            push_patches();
            send_frame(30);
        end
        pix_valid = 1'b0;
        wait_done(6);
        chk("starts_random", start_cnt - s0, 24);
        chk("queue_empty_d", exp_q.size(), 0);

        // Reset while waiting for the core to go idle.
        busy_len = 30;
        s0 = start_cnt;
        build_frame(0);
        push_patches();
        for (int k = 0; k < 4 * IMG_W + 6; k++) send_pixel(img[k / IMG_W][k % IMG_W]);
        pix_valid = 1'b0;
        g = 0;
        while (!core_busy && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        chk("pre_rst_stalled", {pix_ready, core_busy}, 2'b01);
        chk("pre_rst_starts", start_cnt - s0, 2);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_pix_ready", pix_ready, 1'b1);
        chk("midrst_start", start_channel_proc, 1'b0);
        chk("midrst_frame_done", frame_done, 1'b0);
        chk("midrst_out_row", out_row, 0);
        chk("midrst_out_col", out_col, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        s0 = start_cnt;
        build_frame(0);
        push_patches();
        send_frame(0);
        pix_valid = 1'b0;
        wait_done(7);
        chk("starts_after_rst", start_cnt - s0, 8);
        chk_patch("after_rst_first", firsts[firsts.size()-1], firsts[0]);
        f = last_seen;
        chk("after_rst_last_44", f[4][4], 47);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        fails++;
        $display("FAIL watchdog: got no completion by time %0t expected completion", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv5x5_window_gen.md
Name: conv5x5_window_gen

Overview:
Upstream stage of the 5x5 convolution core. Accepts a raster-order 8-bit pixel stream and buffers the last 4 image rows plus a 5x5 shift window. At each valid output position it presents a stable 5x5 patch and issues a one-cycle start to the core. The input stalls until the core has finished with that patch. Stride 1, no padding, so the output grid is (IMG_H-4) x (IMG_W-4).

Parameters:
IMG_W, 28, image width in pixels (>=5)
IMG_H, 28, image height in pixels (>=5)
PIX_W, 8, pixel width; must equal the core INPUT_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pix_in  in  PIX_W  pixel data, raster order
pix_valid  in  1  pix_in is valid
pix_ready  out  1  block can accept a pixel; transfer occurs when pix_valid && pix_ready
patch_pixels  out  PIX_W x [0:4][0:4]  window; [0][*] is the oldest row, [*][0] the leftmost column
start_channel_proc  out  1  one-cycle start pulse to the core
core_busy  in  1  busy output from the core
out_row  out  $clog2(IMG_H)  output row index of the current patch (r-4)
out_col  out  $clog2(IMG_W)  output column index of the current patch (c-4)
frame_done  out  1  one-cycle pulse after the last patch of a frame is released

Behaviour:
- Interface: one clock; reset is synchronous and active-high (port `rst`, sampled on posedge `clk`).
- Reset values:
  - state=S_FILL, pix_ready=1, start_channel_proc=0, frame_done=0.
  - Row and column counters = 0; window registers, out_row and out_col = 0.
  - Line-buffer contents are don't-care.
- States:
  - S_FILL: pix_ready=1.
  - S_ISSUE: start_channel_proc=1 for exactly this cycle.
  - S_WAIT_BUSY: waits for core_busy=1.
  - S_WAIT_IDLE: waits for core_busy=0.
- Transfer at position (r,c) in S_FILL:
  - Window shifts left one column.
  - New column [4:0] = {lb3[c], lb2[c], lb1[c], lb0[c], pix_in}, loaded as rows 0..4 (lb0 = previous row).
  - Line buffers update the same cycle: lb3[c]<=lb2[c], lb2[c]<=lb1[c], lb1[c]<=lb0[c], lb0[c]<=pix_in.
  - c increments and wraps at IMG_W-1; on wrap, r increments and wraps at IMG_H-1.
- Issue decision, made on the same transfer:
  - If r>=4 && c>=4: next state is S_ISSUE; out_row<=r-4 and out_col<=c-4 are latched.
  - Otherwise the block stays in S_FILL.
- Transitions:
  - S_ISSUE -> S_WAIT_BUSY.
  - S_WAIT_BUSY -> S_WAIT_IDLE when core_busy=1.
  - S_WAIT_IDLE -> S_FILL when core_busy=0.
  - If the transfer that caused the issue was the last pixel of the frame (r=IMG_H-1, c=IMG_W-1), frame_done pulses in the cycle that leaves S_WAIT_IDLE.
- Stability: patch_pixels, out_row and out_col are held constant from S_ISSUE until exit from S_WAIT_IDLE. pix_ready=0 throughout this interval.
- Latency: pixel transfer to start pulse = 1 cycle. The core raises busy the cycle after start.
- Counters wrap to (0,0) after the last pixel, so the next frame starts with no gap. Stale line-buffer data is never issued because issue is gated by r>=4.
- Pixel values are unsigned and stored unmodified; no arithmetic is performed on them.
- Reset in any state returns to the reset values on the next edge; any in-flight patch is abandoned.
- core_busy already high while in S_FILL is ignored; it is only sampled in the wait states.

Optional Feature:
Macro CONV_WIN_STALL_CNT_EN.
- Defined: adds output stall_cycles (32-bit) and input stall_clr.
  - Counts cycles with pix_valid=1 && pix_ready=0; saturates at 2^32-1.
  - Cleared by rst or stall_clr; clear has priority over increment.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package conv_pkg holds:
  - PIX_W/INPUT_WIDTH=8 and PATCH_DIM=5.
  - The state typedef {S_FILL, S_ISSUE, S_WAIT_BUSY, S_WAIT_IDLE}.
- Sub-module conv_line_buffer: one IMG_W-deep x PIX_W row delay with write-enable and index inputs, instantiated 4x in a chain. RAM-friendly: synchronous write, asynchronous read at index c.

Test Plan:
- IMG_W=8, IMG_H=6; pixel = r*8+c; core model raises busy 1 cycle after start and holds it 30 cycles -> exactly 8 starts, at (out_row,out_col) = (0,0),(0,1),(0,2),(0,3),(1,0),...,(1,3). First patch: [0][0]=0, [0][4]=4, [4][0]=32, [4][4]=36. Last patch: [4][4]=47.
- Same stream, held during core busy -> pix_ready=0 from S_ISSUE until busy falls; patch_pixels unchanged across the whole interval; no pixel lost or duplicated.
- Two back-to-back frames -> frame_done pulses once per frame; the second frame's first patch equals the first frame's first patch.
- pix_valid toggled randomly 50% -> same 8 patches and values as the continuous case.
- rst asserted mid-frame while in S_WAIT_IDLE -> next cycle pix_ready=1 and start_channel_proc=0. A fresh frame after release yields the correct 8 patches.
- CONV_WIN_STALL_CNT_EN defined, continuous pix_valid, core busy 30 cycles per patch -> stall_cycles = 8 x 32 = 256 per frame (S_ISSUE + S_WAIT_BUSY + 30 busy cycles). stall_clr returns it to 0.
